// File: rtl/fir_mac_sequencer.sv
// Read-side sequencer for the FIR tap delay line: accepts a sample, sweeps all taps
// through a MAC, presents the scaled result. Define FIR_SATURATE_EN to clamp instead of wrap.
module fir_mac_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LENGTH    = 64,
    parameter int unsigned FRAC_BITS = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      shift_enb,
    output logic [WIDTH-1:0]          shift_data,
    output logic [LENGTH-1:0]         pointer,
    input  logic [WIDTH-1:0]          tap_data,
    output logic [$clog2(LENGTH)-1:0] coef_idx,
    input  logic [WIDTH-1:0]          coef_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready
);

    localparam int unsigned IDX_W  = $clog2(LENGTH);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = PROD_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;

    logic signed [PROD_W-1:0] tap_ext, coef_ext, product;
    logic signed [ACC_W-1:0]  sum, scaled;
    logic [WIDTH-1:0]         result;

    // Operands are sign-extended to the product width so the multiply is full precision.
    always_comb begin
        tap_ext  = {{WIDTH{tap_data[WIDTH-1]}}, tap_data};
        coef_ext = {{WIDTH{coef_data[WIDTH-1]}}, coef_data};
        product  = tap_ext * coef_ext;
        sum      = acc_q + {{IDX_W{product[PROD_W-1]}}, product};
        scaled   = sum >>> FRAC_BITS;
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    always_comb begin
        result = scaled[WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        result = scaled[WIDTH-1:0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        shift_enb   = 1'b0;
        shift_data  = in_data;
        pointer     = '0;
        coef_idx    = '0;

        case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                shift_enb = in_valid;
                if (in_valid) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                pointer[IDX_W-1:0] = idx_q;
                coef_idx           = idx_q;
                acc_d              = sum;
                idx_d              = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    out_data_d  = result;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
